cordic_vector_pipe: RTL and testbench
=====================================

Name: cordic_vector_pipe

Overview:
- Parametrised, fully pipelined CORDIC in vectoring mode. Converts a signed Cartesian sample (x, y) to magnitude and phase over the full range −π..+π.
- Accepts one sample per clock and carries a sideband tag alongside each sample.
- Sits in the receive datapath after the I/Q front end and feeds phase/frequency estimators.
- Generalises the fixed 16-bit / 13-stage vectoring core:
  - data width and iteration count are parameters;
  - guard bits prevent internal overflow;
  - reset flushes the valid pipeline.

Parameters:
- WIDTH, 16 — input sample width, two's complement.
- ITER, 13 — number of CORDIC micro-rotation stages; legal range 8..WIDTH.
- TAG_W, 4 — width of the sideband tag carried with each sample; legal range ≥1.

Ports:
- clk  in  1  — single clock, all logic rising-edge.
- sclr_n  in  1  — asynchronous, active-low reset.
- nd  in  1  — new-data strobe; x_in/y_in/tag_in are sampled when high.
- x_in  in  WIDTH  — signed in-phase input.
- y_in  in  WIDTH  — signed quadrature input.
- tag_in  in  TAG_W  — sideband tag, passed through unchanged.
- rdy  out  1  — output-valid strobe.
- mag_out  out  WIDTH+2  — signed magnitude, always ≥ 0.
- phase_out  out  WIDTH  — signed phase, radians × 2^(WIDTH−3), i.e. Q3.(WIDTH−3).
- tag_out  out  TAG_W  — tag aligned with rdy.

Behaviour:
- Reset
  - sclr_n low asynchronously clears every pipeline register, every valid bit, rdy, mag_out, phase_out and tag_out to 0.
  - Reset asserted mid-stream discards all in-flight samples; no rdy pulse follows reset release until new nd.
- Throughput and handshake
  - One sample per cycle; there is no backpressure.
  - A valid bit travels with each sample. rdy is high for exactly one cycle per accepted nd.
  - Gaps in nd produce matching gaps in rdy.
- Latency
  - L = ITER+2 cycles from the nd edge to the rdy edge: stage 0 pre-rotation, ITER rotation stages, one output register.
  - With GAIN_COMP_EN, L = ITER+3.
- Datapath width
  - Internal x/y are WIDTH+2 bits, sign-extended at stage 0, so −2^(WIDTH−1) negation and CORDIC gain growth cannot overflow.
  - Internal z is WIDTH+1 bits; phase_out takes its low WIDTH bits, and the ±π range always fits.
- Stage 0 (pre-rotation), applied only when nd is high
  - x<0, y≥0: x0=y, y0=−x, z0=+π/2.
  - x<0, y<0: x0=−y, y0=x, z0=−π/2.
  - Otherwise: pass through, z0=0.
- Stage i (0..ITER−1)
  - If y_i<0: x += y>>>i, y −= ... sign convention as the standard vectoring step, i.e. x−=d·(y>>>i), y+=d·(x>>>i), z−=d·atan(2^−i), with d = −sign(y_i).
  - Shifts are arithmetic.
- Angle table
  - Constant table of atan(2^−i) at 2^30 scale, 32-bit.
  - Each entry is rounded to WIDTH−3 fraction bits: add 2^(32−WIDTH), then shift right by 33−WIDTH.
  - π/2 constant is derived the same way.
- Outputs
  - mag_out = final x, uncompensated, gain ≈1.6468.
  - phase_out = final z.
  - tag_out = the tag delayed to align with rdy.
- Boundary conditions
  - x=y=0 → mag 0, phase within ±ITER LSB of 0.
  - x<0, y=0 → phase ≈ +π (positive).
  - x=y=−2^(WIDTH−1) → no wrap.
  - nd high every cycle → continuous rdy after L cycles.

Optional Feature:
- GAIN_COMP_EN defined: adds one pipeline stage that scales final x by 1/K.
  - Constant multiply 0.607253 × 2^WIDTH, 18-bit constant for WIDTH=16, rounded, then shifted back.
  - mag_out ≈ true magnitude, fits WIDTH+1 bits, zero-extended to WIDTH+2.
  - Latency becomes ITER+3.
- Not defined: no multiplier; mag_out = K·|v|; latency ITER+2.

Test Plan:
- WIDTH=16, ITER=13, single nd with x=1000, y=0, tag=5 → rdy exactly at cycle 15.
  - mag_out=1647±2 (1000±2 with GAIN_COMP_EN, rdy at cycle 16).
  - phase_out=0±13, tag_out=5.
- x=0, y=1000 → phase_out=12868±13.
- x=−1000, y=0 → phase_out=+25736±13.
- x=−1000, y=−1000 → phase_out=−19302±13.
- x=y=−32768 → mag_out=76322±40 (46341±30 compensated), phase_out=−19302±13, no sign flip.
- nd high 20 consecutive cycles with incrementing tags 0..15 wrapping → 20 contiguous rdy cycles, tags in order.
- Pull sclr_n low 5 cycles after nd → all outputs and rdy 0 immediately.
  - No rdy after release until a new nd, then rdy after exactly L cycles.

Source files
------------

// File: rtl/cordic_vector_pipe_if.sv
// cordic_vector_pipe_if: sample-in / result-out bundle for cordic_vector_pipe.
// master drives samples, slave (the core) returns magnitude, phase and tag.
interface cordic_vector_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic                    nd;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic [TAG_W-1:0]        tag_in;
    logic                    rdy;
    logic signed [WIDTH+1:0] mag_out;
    logic signed [WIDTH-1:0] phase_out;
    logic [TAG_W-1:0]        tag_out;

    modport master (
        output nd, x_in, y_in, tag_in,
        input  rdy, mag_out, phase_out, tag_out
    );

    modport slave (
        input  nd, x_in, y_in, tag_in,
        output rdy, mag_out, phase_out, tag_out
    );
endinterface

// File: rtl/cordic_vector_pipe.sv
// cordic_vector_pipe: pipelined vectoring CORDIC, (x,y) -> (mag, phase, tag).
// Define GAIN_COMP_EN to add a 1/K magnitude scaling stage (+1 latency).
module cordic_vector_pipe #(
    parameter int WIDTH = 16,
    parameter int ITER  = 13,
    parameter int TAG_W = 4
) (
    input logic                 clk,
    input logic                 sclr_n,
    cordic_vector_pipe_if.slave bus
);

    localparam int XW = WIDTH + 2;
    localparam int ZW = WIDTH + 1;

    typedef logic signed [XW-1:0] xw_t;
    typedef logic signed [ZW-1:0] zw_t;

    function automatic logic [31:0] atan_q30(input int i);
        case (i)
            0: atan_q30 = 32'd843314857;
            1: atan_q30 = 32'd497837829;
            2: atan_q30 = 32'd263043837;
            3: atan_q30 = 32'd133525159;
            4: atan_q30 = 32'd67021687;
            5: atan_q30 = 32'd33543516;
            6: atan_q30 = 32'd16775851;
            7: atan_q30 = 32'd8388437;
            8: atan_q30 = 32'd4194283;
            9: atan_q30 = 32'd2097149;
            default:
                atan_q30 = (i < 31) ? (32'd1 << (30 - i)) : 32'd0;
        endcase
    endfunction

    function automatic zw_t to_q(input logic [31:0] a);
        logic [63:0] t;
        t = ({32'd0, a} + (64'd1 << (32 - WIDTH))) >> (33 - WIDTH);
        return t[ZW-1:0];
    endfunction

    localparam zw_t HALF_PI = to_q(32'd1686629713);

    xw_t              x_q [0:ITER];
    xw_t              x_d [0:ITER];
    xw_t              y_q [0:ITER];
    xw_t              y_d [0:ITER];
    zw_t              z_q [0:ITER];
    zw_t              z_d [0:ITER];
    logic [TAG_W-1:0] t_q [0:ITER];
    logic [TAG_W-1:0] t_d [0:ITER];
    logic             v_q [0:ITER];

    xw_t  xs, ys, dx, dy;
    logic inc;

    always_comb begin
        xs = {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
        ys = {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
        x_d[0] = x_q[0];
        y_d[0] = y_q[0];
        z_d[0] = z_q[0];
        t_d[0] = t_q[0];
        if (bus.nd) begin
            t_d[0] = bus.tag_in;
            unique case (1'b1)
                xs[XW-1] && !ys[XW-1]: begin
                    x_d[0] = ys;
                    y_d[0] = -xs;
                    z_d[0] = HALF_PI;
                end
                xs[XW-1] && ys[XW-1]: begin
                    x_d[0] = -ys;
                    y_d[0] = xs;
                    z_d[0] = -HALF_PI;
                end
                default: begin
                    x_d[0] = xs;
                    y_d[0] = ys;
                    z_d[0] = '0;
                end
            endcase
        end
        dx  = '0;
        dy  = '0;
        inc = 1'b0;
        for (int i = 0; i < ITER; i++) begin
            // y==0 steers z toward 0 so a zero vector ends near phase 0
            inc = !y_q[i][XW-1] &&
                  ((y_q[i] != '0) || z_q[i][ZW-1] || (z_q[i] == '0));
            dx  = y_q[i] >>> i;
            dy  = x_q[i] >>> i;
            if (inc) begin
                x_d[i+1] = x_q[i] + dx;
                y_d[i+1] = y_q[i] - dy;
                z_d[i+1] = z_q[i] + to_q(atan_q30(i));
            end else begin
                x_d[i+1] = x_q[i] - dx;
                y_d[i+1] = y_q[i] + dy;
                z_d[i+1] = z_q[i] - to_q(atan_q30(i));
            end
            t_d[i+1] = t_q[i];
        end
    end

    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            for (int i = 0; i <= ITER; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= '0;
                t_q[i] <= '0;
                v_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i <= ITER; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
                z_q[i] <= z_d[i];
                t_q[i] <= t_d[i];
            end
            v_q[0] <= bus.nd;
            for (int i = 1; i <= ITER; i++) begin
                v_q[i] <= v_q[i-1];
            end
        end
    end

    logic [XW-1:0]    src_mag;
    zw_t              src_z;
    logic [TAG_W-1:0] src_t;
    logic             src_v;
    logic             unused_ok;

`ifdef GAIN_COMP_EN
    localparam logic [63:0] KINV =
        ((64'd607253 << WIDTH) + 64'd500000) / 64'd1000000;
    localparam logic [XW-1:0]   KC  = KINV[XW-1:0];
    localparam logic [2*XW-1:0] RND = {{(2*XW-1){1'b0}}, 1'b1} << (WIDTH - 1);

    logic [2*XW-1:0]  prod;
    logic [WIDTH:0]   mc_q;
    zw_t              zc_q;
    logic [TAG_W-1:0] tc_q;
    logic             vc_q;

    // final x is never negative, so an unsigned multiply is exact
    assign prod = {{XW{1'b0}}, x_q[ITER]} * {{XW{1'b0}}, KC} + RND;

    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            mc_q <= '0;
            zc_q <= '0;
            tc_q <= '0;
            vc_q <= 1'b0;
        end else begin
            mc_q <= prod[WIDTH +: WIDTH+1];
            zc_q <= z_q[ITER];
            tc_q <= t_q[ITER];
            vc_q <= v_q[ITER];
        end
    end

    assign src_mag   = {1'b0, mc_q};
    assign src_z     = zc_q;
    assign src_t     = tc_q;
    assign src_v     = vc_q;
    assign unused_ok = ^{src_z[WIDTH], prod[2*XW-1:2*WIDTH+1], prod[WIDTH-1:0]};
`else
    assign src_mag   = x_q[ITER];
    assign src_z     = z_q[ITER];
    assign src_t     = t_q[ITER];
    assign src_v     = v_q[ITER];
    assign unused_ok = src_z[WIDTH];
`endif

    logic             rdy_q;
    logic [XW-1:0]    mag_q;
    logic [WIDTH-1:0] ph_q;
    logic [TAG_W-1:0] tg_q;

    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            rdy_q <= 1'b0;
            mag_q <= '0;
            ph_q  <= '0;
            tg_q  <= '0;
        end else begin
            rdy_q <= src_v;
            mag_q <= src_mag;
            ph_q  <= src_z[WIDTH-1:0];
            tg_q  <= src_t;
        end
    end

    assign bus.rdy       = rdy_q;
    assign bus.mag_out   = mag_q;
    assign bus.phase_out = ph_q;
    assign bus.tag_out   = tg_q;

endmodule

// File: tb/tb_cordic_vector_pipe.sv
// tb_cordic_vector_pipe: vector table + scoreboard bench for cordic_vector_pipe.
// Honours GAIN_COMP_EN for expected magnitudes and latency.
module tb_cordic_vector_pipe;

    localparam int W  = 16;
    localparam int IT = 13;
    localparam int TW = 4;
`ifdef GAIN_COMP_EN
    localparam int L  = IT + 3;
    localparam bit GC = 1'b1;
`else
    localparam int L  = IT + 2;
    localparam bit GC = 1'b0;
`endif

    logic clk    = 1'b0;
    logic sclr_n = 1'b0;

    always #5 clk = ~clk;

    cordic_vector_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    cordic_vector_pipe #(.WIDTH(W), .ITER(IT), .TAG_W(TW)) dut (
        .clk    (clk),
        .sclr_n (sclr_n),
        .bus    (bus)
    );

    typedef struct {
        int x;
        int y;
        int tg;
        int m;
        int tm;
        int mc;
        int tmc;
        int p;
        int tp;
    } vec_t;

    typedef struct {
        int tg;
        int m;
        int tm;
        int p;
        int tp;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tv[11];
    int   nchk = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   nrdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act,
                       input longint exp, input longint tol);
        nchk++;
        if (act < exp - tol || act > exp + tol) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    always @(negedge clk) begin
        if (sclr_n && bus.rdy) begin
            nrdy++;
            if (sb.size() == 0) begin
                chk("rdy_unexpected", longint'(bus.rdy), 0, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("latency", cyc, mon_e.due, 0);
                chk("mag", longint'(bus.mag_out), mon_e.m, mon_e.tm);
                chk("phase", longint'(bus.phase_out), mon_e.p, mon_e.tp);
                chk("tag", longint'(bus.tag_out), mon_e.tg, 0);
            end
        end
    end

    task automatic send(input vec_t v, input bit push);
        exp_t e;
        bus.nd     = 1'b1;
        bus.x_in   = W'(v.x);
        bus.y_in   = W'(v.y);
        bus.tag_in = TW'(v.tg);
        if (push) begin
            e.tg  = v.tg % 16;
            e.m   = GC ? v.mc : v.m;
            e.tm  = GC ? v.tmc : v.tm;
            e.p   = v.p;
            e.tp  = v.tp;
            e.due = cyc + L;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.nd = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0, 0);
            sb.delete();
        end
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_rdy"}, longint'(bus.rdy), 0, 0);
        chk({pfx, "_mag"}, longint'(bus.mag_out), 0, 0);
        chk({pfx, "_phase"}, longint'(bus.phase_out), 0, 0);
        chk({pfx, "_tag"}, longint'(bus.tag_out), 0, 0);
    endtask

    initial begin
        vec_t v;
        int   n0;
        bus.nd     = 1'b0;
        bus.x_in   = '0;
        bus.y_in   = '0;
        bus.tag_in = '0;

        tv[0]  = '{1000, 0, 5, 1647, 2, 1000, 2, 0, 13};
        tv[1]  = '{0, 1000, 1, 1647, 3, 1000, 3, 12868, 13};
        tv[2]  = '{-1000, 0, 2, 1647, 3, 1000, 3, 25736, 13};
        tv[3]  = '{-1000, -1000, 3, 2329, 4, 1414, 3, -19302, 13};
        tv[4]  = '{-32768, -32768, 4, 76322, 40, 46341, 30, -19302, 13};
        tv[5]  = '{0, 0, 6, 0, 0, 0, 0, 0, 13};
        tv[6]  = '{0, -1000, 7, 1647, 3, 1000, 3, -12868, 13};
        tv[7]  = '{1000, 1000, 8, 2329, 4, 1414, 3, 6434, 13};
        tv[8]  = '{32767, 0, 9, 53959, 40, 32767, 30, 0, 13};
        tv[9]  = '{-32768, 0, 10, 53962, 40, 32768, 30, 25736, 13};
        tv[10] = '{3000, -4000, 11, 8234, 6, 5000, 4, -7596, 13};

        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        sclr_n = 1'b1;
        @(negedge clk);

        foreach (tv[k]) begin
            send(tv[k], 1'b1);
            idle(1);
        end
        drain();

        for (int i = 0; i < 20; i++) begin
            v    = tv[0];
            v.tg = i % 16;
            send(v, 1'b1);
        end
        idle(1);
        drain();

        send(tv[7], 1'b0);
        idle(4);
        sclr_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        repeat (3) @(negedge clk);
        sclr_n = 1'b1;
        n0 = nrdy;
        repeat (30) @(negedge clk);
        chk("rdy_after_reset", nrdy - n0, 0, 0);

        send(tv[10], 1'b1);
        idle(1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
